// File: rtl/csa_accum.sv
// ---------------------------------------------------------------------------
// csa_accum
//
// Streaming carry-save accumulator. Operands arrive one per cycle under a
// valid/ready handshake. Each one is folded into a registered redundant
// (carry, sum) pair using a single 3:2 compressor row, so the per-beat
// critical path stays one full-adder deep at any width. When the last beat
// of a frame is accepted, the pair is presented under a second handshake.
// All arithmetic is modulo 2^W.
//
// Optional feature (compile-time macro CSA_ACCUM_RESOLVE_EN):
//   When the macro is defined, a one-cycle RES state is added. In RES a
//   full-width carry-propagate adder resolves the pair into out_sum. This
//   adds one cycle of latency. When the macro is undefined, there is no RES
//   state, no adder and no out_sum port.
//
// Parameters:
//   W      operand / result width in bits (W >= 2)
//   CNT_W  width of the frame beat counter
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat offered
//   in_ready   block accepts a beat this cycle (high only while accumulating)
//   in_data    operand, W bits
//   in_last    beat is the final operand of the frame
//   out_valid  frame result presented
//   out_ready  consumer takes the result
//   out_c      redundant carry vector
//   out_s      redundant sum vector
//   out_count  operands in the frame, saturating at 2^CNT_W-1
//   out_sum    (out_c + out_s) mod 2^W   [CSA_ACCUM_RESOLVE_EN only]
// ---------------------------------------------------------------------------
module csa_accum #(
   parameter int W     = 89,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_c,
   output logic [W-1:0]     out_s,
   output logic [CNT_W-1:0] out_count
`ifdef CSA_ACCUM_RESOLVE_EN
   ,
   output logic [W-1:0]     out_sum
`endif
);

   // ------------------------------------------------------------------------
   // Control states
   // ------------------------------------------------------------------------
`ifdef CSA_ACCUM_RESOLVE_EN
   typedef enum logic [1:0] {
      ACC = 2'd0,   // accepting operand beats
      RES = 2'd1,   // resolving the redundant pair into a binary sum
      OUT = 2'd2    // presenting the frame result
   } state_t;
`else
   typedef enum logic [1:0] {
      ACC = 2'd0,   // accepting operand beats
      OUT = 2'd2    // presenting the frame result
   } state_t;
`endif

   state_t state_q;
   state_t state_n;

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   logic [W-1:0]     c_q;
   logic [W-1:0]     s_q;
   logic [CNT_W-1:0] cnt_q;

   // Next-value terms for one accepted beat
   logic [W-1:0]     s_n;
   logic [W-1:0]     c_n;
   logic [W-2:0]     maj_lo;   // carries out of bits 0..W-2; the top carry is dropped
   logic [CNT_W-1:0] cnt_n;

   // Handshake qualifiers
   logic accept;   // operand beat consumed this cycle
   logic fire;     // result taken by the consumer this cycle

   assign accept = in_valid  && (state_q == ACC);
   assign fire   = out_ready && (state_q == OUT);

   // ------------------------------------------------------------------------
   // 3:2 compressor row plus saturating beat counter.
   // The sum keeps every bit position. Each carry moves up one bit, so the
   // carry leaving bit W-1 is outside the modulo-2^W result and is dropped.
   // This keeps (c + s) mod 2^W equal to the running total of the frame.
   // ------------------------------------------------------------------------
   always_comb begin
      s_n    = c_q ^ s_q ^ in_data;
      maj_lo = (c_q[W-2:0] & s_q[W-2:0])
             | (c_q[W-2:0] & in_data[W-2:0])
             | (s_q[W-2:0] & in_data[W-2:0]);
      c_n    = {maj_lo, 1'b0};
      // Saturation only limits the reported count; it never gates the
      // arithmetic above.
      cnt_n  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a value first, so no path can
      // leave it unassigned and infer a latch.
      state_n = state_q;
      unique case (state_q)
         ACC: begin
            if (accept && in_last) begin
`ifdef CSA_ACCUM_RESOLVE_EN
               state_n = RES;
`else
               state_n = OUT;
`endif
            end
         end
`ifdef CSA_ACCUM_RESOLVE_EN
         RES: state_n = OUT;
`endif
         OUT: begin
            if (out_ready) state_n = ACC;
         end
         default: state_n = ACC;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so all registers
      // update together from values sampled before the edge.
      if (rst) state_q <= ACC;
      else     state_q <= state_n;
   end

   // ------------------------------------------------------------------------
   // Accumulator registers.
   // The result handshake clears the pair and the counter, so the next frame
   // starts from zero. Beats offered outside ACC are not accepted, so the
   // pair holds still while OUT waits on backpressure.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: these are plain flops, not a memory array, so the asynchronous
      // reset clears them at no cost. A partial frame is discarded at once.
      if (rst) begin
         c_q   <= '0;
         s_q   <= '0;
         cnt_q <= '0;
      end else if (fire) begin
         c_q   <= '0;
         s_q   <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         c_q   <= c_n;
         s_q   <= s_n;
         cnt_q <= cnt_n;
      end
   end

`ifdef CSA_ACCUM_RESOLVE_EN
   // ------------------------------------------------------------------------
   // Resolved sum: one full-width carry-propagate add, performed in RES.
   // The pair is frozen in RES because no beat can be accepted there.
   // ------------------------------------------------------------------------
   logic [W-1:0] sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else if (fire) begin
         sum_q <= '0;
      end else if (state_q == RES) begin
         sum_q <= c_q + s_q;
      end
   end

   assign out_sum = sum_q;
`endif

   // ------------------------------------------------------------------------
   // Outputs.
   // The pair and counter drive the ports directly. While OUT waits on
   // backpressure they are frozen. Reset clears them to zero.
   // ------------------------------------------------------------------------
   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == OUT);
   assign out_c     = c_q;
   assign out_s     = s_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_accum.sv
// ---------------------------------------------------------------------------
// tb_csa_accum
//
// Self-checking bench for csa_accum. Frames are listed in a table, and each
// row holds its operands and hand-computed expected results. The table is
// followed by hand-written sequences for:
//   - backpressure,
//   - asynchronous reset mid-frame,
//   - counter saturation (second instance, CNT_W = 2).
// Inputs are driven on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_csa_accum;

   localparam int W     = 89;
   localparam int CNT_W = 8;
`ifdef CSA_ACCUM_RESOLVE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   // Main instance signals
   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_c;
   logic [W-1:0]     out_s;
   logic [CNT_W-1:0] out_count;
`ifdef CSA_ACCUM_RESOLVE_EN
   logic [W-1:0]     out_sum;
`endif

   // Saturation instance signals (W = 16, CNT_W = 2)
   logic             sat_in_valid;
   logic             sat_in_ready;
   logic [15:0]      sat_in_data;
   logic             sat_in_last;
   logic             sat_out_valid;
   logic             sat_out_ready;
   logic [15:0]      sat_out_c;
   logic [15:0]      sat_out_s;
   logic [1:0]       sat_out_count;
`ifdef CSA_ACCUM_RESOLVE_EN
   logic [15:0]      sat_out_sum;
`endif

   csa_accum #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_s     (out_s),
      .out_count (out_count)
`ifdef CSA_ACCUM_RESOLVE_EN
      ,
      .out_sum   (out_sum)
`endif
   );

   csa_accum #(.W(16), .CNT_W(2)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sat_in_valid),
      .in_ready  (sat_in_ready),
      .in_data   (sat_in_data),
      .in_last   (sat_in_last),
      .out_valid (sat_out_valid),
      .out_ready (sat_out_ready),
      .out_c     (sat_out_c),
      .out_s     (sat_out_s),
      .out_count (sat_out_count)
`ifdef CSA_ACCUM_RESOLVE_EN
      ,
      .out_sum   (sat_out_sum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Redundant pair resolved by the bench, modulo 2^W
   function automatic logic [W-1:0] pair_sum();
      logic [W-1:0] t;
      t = out_c + out_s;
      return t;
   endfunction

   // One frame on the main instance. Ends with the result on the outputs;
   // the result is not yet taken.
   task automatic run_frame(input string tag, input int n, input logic [3:0][W-1:0] ops,
                            input logic [W-1:0] exp_sum, input logic [CNT_W-1:0] exp_cnt);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, " in_ready"}, in_ready, 1'b1);
         in_valid = 1'b1;
         in_data  = ops[i];
         in_last  = (i == n - 1);
      end
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k == 1) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = '0;
         end
         check({tag, " out_valid latency"}, out_valid, (k == LAT));
      end
      check({tag, " sum"},   pair_sum(), exp_sum);
      check({tag, " c0"},    out_c[0],   1'b0);
      check({tag, " count"}, out_count,  exp_cnt);
      check({tag, " in_ready low"}, in_ready, 1'b0);
`ifdef CSA_ACCUM_RESOLVE_EN
      check({tag, " out_sum"}, out_sum, exp_sum);
`endif
      if (n == 1) begin
         check({tag, " single c"}, out_c, '0);
         check({tag, " single s"}, out_s, ops[0]);
      end
   endtask

   // Take the result and confirm the block is back in ACC and cleared.
   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " rel out_valid"}, out_valid, 1'b0);
      check({tag, " rel in_ready"},  in_ready,  1'b1);
      check({tag, " rel c"},         out_c,     '0);
      check({tag, " rel s"},         out_s,     '0);
      check({tag, " rel count"},     out_count, '0);
   endtask

   typedef struct packed {
      int                 n;
      logic [3:0][W-1:0]  op;
      logic [W-1:0]       exp_sum;
      logic [CNT_W-1:0]   exp_cnt;
   } vec_t;

   localparam int NV = 5;
   vec_t vecs [NV];

   logic [W-1:0] all_ones;
   logic [W-1:0] snap_c, snap_s;

   initial begin
      // ---------------- table ----------------
      all_ones = '1;
      for (int i = 0; i < NV; i++) vecs[i] = '0;
      // 3 + 5 + 7 = 15
      vecs[0].n = 3; vecs[0].op[0] = 3; vecs[0].op[1] = 5; vecs[0].op[2] = 7;
      vecs[0].exp_sum = 15; vecs[0].exp_cnt = 3;
      // 3 * (2^89-1) mod 2^89 = 2^89-3
      vecs[1].n = 3; vecs[1].op[0] = all_ones; vecs[1].op[1] = all_ones; vecs[1].op[2] = all_ones;
      vecs[1].exp_sum = all_ones - 2; vecs[1].exp_cnt = 3;
      // single beat: c = 0, s = operand
      vecs[2].n = 1; vecs[2].op[0] = 89'h1_0000_0001;
      vecs[2].exp_sum = 89'h1_0000_0001; vecs[2].exp_cnt = 1;
      // 1 + 2^88 + 2^88 = 1 mod 2^89
      vecs[3].n = 3; vecs[3].op[0] = 1; vecs[3].op[1] = {1'b1, 88'd0}; vecs[3].op[2] = {1'b1, 88'd0};
      vecs[3].exp_sum = 1; vecs[3].exp_cnt = 3;
      // 0xFFFF_FFFF + 1 + 0xA + 0x5 = 0x1_0000_000F
      vecs[4].n = 4; vecs[4].op[0] = 89'hFFFF_FFFF; vecs[4].op[1] = 1; vecs[4].op[2] = 89'hA; vecs[4].op[3] = 89'h5;
      vecs[4].exp_sum = 89'h1_0000_000F; vecs[4].exp_cnt = 4;

      // ---------------- reset ----------------
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      sat_in_valid = 1'b0; sat_in_data = '0; sat_in_last = 1'b0; sat_out_ready = 1'b0;
      #12;
      check("reset in_ready",  in_ready,  1'b1);
      check("reset out_valid", out_valid, 1'b0);
      check("reset c",         out_c,     '0);
      check("reset s",         out_s,     '0);
      check("reset count",     out_count, '0);
`ifdef CSA_ACCUM_RESOLVE_EN
      check("reset out_sum",   out_sum,   '0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // ---------------- table-driven frames ----------------
      for (int v = 0; v < NV; v++) begin
         run_frame($sformatf("vec%0d", v), vecs[v].n, vecs[v].op, vecs[v].exp_sum, vecs[v].exp_cnt);
         release_result($sformatf("vec%0d", v));
      end

      // ---------------- backpressure ----------------
      begin
         logic [3:0][W-1:0] ops;
         ops = '0; ops[0] = 10; ops[1] = 20;
         run_frame("bp", 2, ops, 30, 2);
         snap_c = out_c;
         snap_s = out_s;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 89'd123; in_last = 1'b1;
            check("bp in_ready",  in_ready,  1'b0);
            check("bp out_valid", out_valid, 1'b1);
            check("bp stable c",  out_c,     snap_c);
            check("bp stable s",  out_s,     snap_s);
            check("bp count",     out_count, 2);
         end
         @(negedge clk);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
         check("bp post in_ready", in_ready,  1'b1);
         check("bp post c",        out_c,     '0);
         check("bp post s",        out_s,     '0);
         check("bp post count",    out_count, '0);
         @(negedge clk);
         check("bp no beat consumed", out_count, '0);
         ops = '0; ops[0] = 6;
         run_frame("bp next", 1, ops, 6, 1);
         release_result("bp next");
      end

      // ---------------- asynchronous reset mid-frame ----------------
      begin
         logic [3:0][W-1:0] ops;
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 89'd9; in_last = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b0; in_data = '0;
         check("ar pre count", out_count, 2);
         check("ar pre sum",   pair_sum(), 18);
         #1 rst = 1'b1;
         #1;
         check("ar c",         out_c,     '0);
         check("ar s",         out_s,     '0);
         check("ar count",     out_count, '0);
         check("ar in_ready",  in_ready,  1'b1);
         check("ar out_valid", out_valid, 1'b0);
         #1 rst = 1'b0;
         ops = '0; ops[0] = 4;
         run_frame("ar next", 1, ops, 4, 1);
         release_result("ar next");
      end

      // ---------------- saturation, CNT_W = 2 ----------------
      begin
         logic [15:0] t;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("sat in_ready", sat_in_ready, 1'b1);
            sat_in_valid = 1'b1; sat_in_data = 16'd1; sat_in_last = (i == 5);
         end
         for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
               sat_in_valid = 1'b0; sat_in_last = 1'b0; sat_in_data = '0;
            end
            check("sat out_valid latency", sat_out_valid, (k == LAT));
         end
         t = sat_out_c + sat_out_s;
         check("sat count", sat_out_count, 2'd3);
         check("sat sum",   t,             16'd6);
`ifdef CSA_ACCUM_RESOLVE_EN
         check("sat out_sum", sat_out_sum, 16'd6);
`endif
         @(negedge clk);
         sat_out_ready = 1'b1;
         @(negedge clk);
         sat_out_ready = 1'b0;
         check("sat rel count",    sat_out_count, 2'd0);
         check("sat rel in_ready", sat_in_ready,  1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
